// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit for the EX stage.
//   Iterative shift-add multiplier and restoring divider (one bit per cycle).
//   Optional macro MULDIV_FAST_MUL_EN: single-cycle 33x33 signed multiply.
//   Ports:
//     clk, reset_n          clock, async active-low reset
//     start, funct3         valid M instruction in ID/EX and its op
//     DataA, DataB, AddrD   rs1/rs2 operands and destination register
//     flush                 kills an operation in flight
//     stall                 holds PC, IF/ID, ID/EX (combinational)
//     busy                  MUL or DIV state (registered)
//     done                  one-cycle result-valid pulse
//     result, AddrD_out     registered result and its destination
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] DataA,
  input  logic [XLEN-1:0] DataB,
  input  logic [4:0]      AddrD,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      AddrD_out
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0] op_q, op_d;
  logic [4:0] addr_q, addr_d, addr_out_q, addr_out_d;
  logic neg_q, neg_d, rneg_q, rneg_d;
  logic a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN:0] mul_sum, div_top;
  logic [XLEN-1:0] div_diff, quo, rem, mul_res, div_res;
  logic [2*XLEN-1:0] mul_nx, div_nx, prod;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_p;
`endif
  always_comb begin
    // Operand signedness: DIV/REM both signed; MULH both; MULHSU rs1 only.
    a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg = a_sgn & DataA[XLEN-1];
    b_neg = b_sgn & DataB[XLEN-1];
    a_mag = a_neg ? -DataA : DataA;
    b_mag = b_neg ? -DataB : DataB;
    div_zero = DataB == '0;
    div_ovf = ~funct3[0] && DataA == {1'b1, {(XLEN-1){1'b0}}} && &DataB;
    spec_res = div_zero ? (funct3[1] ? DataA : '1) : (funct3[1] ? '0 : DataA);
`ifdef MULDIV_FAST_MUL_EN
    fast_p = $signed({a_neg, DataA}) * $signed({b_neg, DataB});
    special = ~funct3[2] | div_zero | div_ovf;
    spec_res = funct3[2] ? spec_res : (funct3[1:0] == 2'b00 ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN]);
`else
    special = funct3[2] & (div_zero | div_ovf);
`endif
    // Multiply step: acc = {partial product, remaining multiplier bits}.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx = {mul_sum, acc_q[XLEN-1:1]};
    // Divide step: acc = {remainder, dividend/quotient}; top is 2*rem + next bit.
    div_top = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top[XLEN-1:0] - b_q;
    div_nx = (div_top >= {1'b0, b_q}) ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                                      : {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod = neg_q ? -mul_nx : mul_nx;
    mul_res = op_q == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo = neg_q ? -div_nx[XLEN-1:0] : div_nx[XLEN-1:0];
    rem = rneg_q ? -div_nx[2*XLEN-1:XLEN] : div_nx[2*XLEN-1:XLEN];
    div_res = op_q[1] ? rem : quo;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    addr_d = addr_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    result_d = result_q;
    addr_out_d = addr_out_q;
    case (state_q)
      IDLE: if (start) begin
        op_d = funct3[1:0];
        addr_d = AddrD;
        a_d = a_mag;
        b_d = b_mag;
        neg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d = '0;
        acc_d = {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
        state_d = special ? DONE : (funct3[2] ? DIV : MUL);
        result_d = special ? spec_res : result_q;
        addr_out_d = special ? AddrD : addr_out_q;
      end
      MUL, DIV: begin
        acc_d = state_q == MUL ? mul_nx : div_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          result_d = state_q == MUL ? mul_res : div_res;
          addr_out_d = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything and never touches the visible result.
    if (flush) begin
      state_d = IDLE;
      result_d = result_q;
      addr_out_d = addr_out_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      addr_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      result_q <= '0;
      addr_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      addr_q <= addr_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      result_q <= result_d;
      addr_out_q <= addr_out_d;
    end
  end
  assign stall = (state_q == IDLE && start && !flush) || state_q == MUL || state_q == DIV;
  assign busy = state_q == MUL || state_q == DIV;
  assign done = state_q == DONE;
  assign result = result_q;
  assign AddrD_out = addr_out_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven, scoreboarded self-checking bench for ex_muldiv.
module tb_ex_muldiv;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] DataA = '0, DataB = '0;
  logic [4:0] AddrD = '0;
  logic stall, busy, done;
  logic [31:0] result;
  logic [4:0] AddrD_out;
  int n_vec = 0, n_err = 0;
  logic [31:0] sb[$];

  ex_muldiv dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
    .DataA(DataA), .DataB(DataB), .AddrD(AddrD), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result), .AddrD_out(AddrD_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

`ifdef MULDIV_FAST_MUL_EN
  localparam logic [2:0] RST_OP = 3'b101;
`else
  localparam logic [2:0] RST_OP = 3'b011;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2, ub, p;
    logic [63:0] up;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    ub = {32'b0, b};
    up = {32'b0, a} * {32'b0, b};
    ovf = a == 32'h80000000 && b == 32'hffffffff;
    case (f)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: return b == 0 ? 32'hffffffff : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hffffffff : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv);
    int lat, cyc, bad;
    logic [31:0] e;
    lat = (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hffffffff))) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) lat = 1;
`endif
    @(negedge clk);
    start = 1'b1; funct3 = f; DataA = a; DataB = b; AddrD = rd;
    sb.push_back(expv);
    #1 bad = (stall !== 1'b1) ? 1 : 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      #1;
      if (done !== 1'b1) bad += ((stall !== 1'b1) ? 1 : 0) + ((busy !== 1'b1) ? 1 : 0);
    end
    if (done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL timeout: f3=%0d a=%h b=%h got no done, expected one", f, a, b);
      e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      chk("latency", 32'(cyc), 32'(lat));
      chk("result", result, e);
      chk("addr_out", {27'b0, AddrD_out}, {27'b0, rd});
      chk("stall_in_done", {31'b0, stall}, 32'h0);
      chk("busy_in_done", {31'b0, busy}, 32'h0);
    end
    chk("stall_busy_profile", 32'(bad), 32'h0);
    start = 1'b0;
  endtask

  initial begin
    vec_t vt[16];
    int dn;
    vt[0]  = '{3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe};
    vt[1]  = '{3'd0, 32'hffffffff, 32'hffffffff, 32'h00000001};
    vt[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vt[3]  = '{3'd2, 32'hffffffff, 32'h00000002, 32'hffffffff};
    vt[4]  = '{3'd4, 32'hfffffff9, 32'h00000002, 32'hfffffffd};
    vt[5]  = '{3'd6, 32'hfffffff9, 32'h00000002, 32'hffffffff};
    vt[6]  = '{3'd5, 32'h00000007, 32'h00000002, 32'h00000003};
    vt[7]  = '{3'd5, 32'h00000005, 32'h00000000, 32'hffffffff};
    vt[8]  = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005};
    vt[9]  = '{3'd4, 32'h80000000, 32'hffffffff, 32'h80000000};
    vt[10] = '{3'd6, 32'h80000000, 32'hffffffff, 32'h00000000};
    vt[11] = '{3'd4, 32'h00000007, 32'h00000000, 32'hffffffff};
    vt[12] = '{3'd6, 32'hfffffff9, 32'h00000000, 32'hfffffff9};
    vt[13] = '{3'd2, 32'h80000000, 32'hffffffff, 32'h80000000};
    vt[14] = '{3'd4, 32'h00000007, 32'hfffffffe, 32'hfffffffd};
    vt[15] = '{3'd6, 32'h00000007, 32'hfffffffe, 32'h00000001};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_addr", {27'b0, AddrD_out}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_op(vt[i].f, vt[i].a, vt[i].b, 5'(i + 1), vt[i].exp);
    run_op(3'd0, 32'h12345678, 32'h00000010, 5'd20, 32'h23456780);

    // Back-to-back model-checked operations with random operands.
    for (int i = 0; i < 10; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i == 3) ? 32'h0 : $urandom >> $urandom_range(0, 24);
      run_op(f, a, b, 5'(i + 21), ref_op(f, a, b));
    end

    // Flush in C10 of a DIV: no done, result unchanged.
    run_op(3'd7, 32'h12345678, 32'h0, 5'd3, 32'h12345678);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; DataA = 32'h00001000; DataB = 32'h00000003; AddrD = 5'd4;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_stall", {31'b0, stall}, 32'h0);
    chk("flush_busy", {31'b0, busy}, 32'h0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    chk("flush_done_count", 32'(dn), 32'h0);
    chk("flush_result", result, 32'h12345678);
    chk("flush_addr", {27'b0, AddrD_out}, 32'h3);

    // Asynchronous reset mid-operation.
    start = 1'b1; funct3 = RST_OP; DataA = 32'hffffffff; DataB = 32'h00000003; AddrD = 5'd9;
    repeat (15) @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'h1);
    reset_n = 1'b0; start = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_addr", {27'b0, AddrD_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 32'd14);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
